piso_serializer: RTL and testbench

Parallel-in serial-out serializer: accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock on a single serial line, with a frame strobe and an end-of-word pulse. It is the transmit end of the serial shift link whose receiving end is the team's 4-bit serial-in parallel-out shift register. With the default LSB-first ordering, WIDTH clocks of `b` fed into that receiver leave its `q` equal to the loaded word.

---
 rtl/piso_serializer_if.sv | 11 +
 rtl/piso_serializer.sv | 45 ++++
 tb/tb_piso_serializer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake and serial output bundle for piso_serializer
interface piso_serializer_if #(parameter int WIDTH = 4);
  logic load_valid;
  logic load_ready;
  logic [WIDTH-1:0] d;
  logic b;
  logic frame;
  logic done;
  modport master(output load_valid, d, input load_ready, b, frame, done);
  modport slave(input load_valid, d, output load_ready, b, frame, done);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded word shifted out one bit per clock with frame and done strobes
module piso_serializer #(
  parameter int WIDTH = 4,
  parameter bit LSB_FIRST = 1
) (
  input logic clk,
  input logic rst,
  piso_serializer_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t st, nst;
  logic [WIDTH-1:0] sr, nsr, src;
  logic [CW-1:0] cnt, ncnt;
  logic acc, nb, ndone;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      sr <= '0;
      cnt <= '0;
      s.b <= 1'b0;
      s.frame <= 1'b0;
      s.done <= 1'b0;
    end else begin
      st <= nst;
      sr <= nsr;
      cnt <= ncnt;
      s.b <= nb;
      s.frame <= nst == SHIFT;
      s.done <= ndone;
    end
  always_comb begin
    acc = s.load_valid && s.load_ready;
    nst = (acc || (st == SHIFT && cnt != '0)) ? SHIFT : IDLE;
  end
  // an accepted word bypasses the shift register so its first bit goes out on the same edge
  always_comb begin
    s.load_ready = st == IDLE || cnt == '0;
    src = acc ? s.d : sr;
    nb = (nst == SHIFT) && (LSB_FIRST ? src[0] : src[WIDTH-1]);
    nsr = LSB_FIRST ? src >> 1 : src << 1;
    ncnt = acc ? CW'(WIDTH - 1) : (cnt != '0 ? cnt - 1'b1 : cnt);
    ndone = nst == SHIFT && ncnt == '0;
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed vectors for LSB/MSB-first WIDTH=4 and LSB-first WIDTH=8 serializers
module tb_piso_serializer;
  logic clk, rst;
  logic [2:0] lv, bv, fv, dv, rv;
  logic [3:0] d0, d1, rq;
  logic [7:0] d8;
  int nvec = 0, nmis = 0;
  piso_serializer_if #(.WIDTH(4)) i0();
  piso_serializer_if #(.WIDTH(4)) i1();
  piso_serializer_if #(.WIDTH(8)) i8();
  piso_serializer #(.WIDTH(4), .LSB_FIRST(1)) u0(.clk(clk), .rst(rst), .s(i0));
  piso_serializer #(.WIDTH(4), .LSB_FIRST(0)) u1(.clk(clk), .rst(rst), .s(i1));
  piso_serializer #(.WIDTH(8), .LSB_FIRST(1)) u8(.clk(clk), .rst(rst), .s(i8));
  assign i0.load_valid = lv[0];
  assign i1.load_valid = lv[1];
  assign i8.load_valid = lv[2];
  assign i0.d = d0;
  assign i1.d = d1;
  assign i8.d = d8;
  assign bv = {i8.b, i1.b, i0.b};
  assign fv = {i8.frame, i1.frame, i0.frame};
  assign dv = {i8.done, i1.done, i0.done};
  assign rv = {i8.load_ready, i1.load_ready, i0.load_ready};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rq <= {i0.b, rq[3:1]};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int u, input string tag);
    chk({tag, ".b"}, 32'(bv[u]), 0);
    chk({tag, ".frame"}, 32'(fv[u]), 0);
    chk({tag, ".done"}, 32'(dv[u]), 0);
    chk({tag, ".ready"}, 32'(rv[u]), 1);
  endtask
  task automatic word(input int u, input string tag, input logic [7:0] eb, input int n, input bit keep);
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0 && !keep) lv[u] = 1'b0;
      chk($sformatf("%s.b%0d", tag, i), 32'(bv[u]), 32'(eb[i]));
      chk($sformatf("%s.frame%0d", tag, i), 32'(fv[u]), 1);
      chk($sformatf("%s.done%0d", tag, i), 32'(dv[u]), 32'(i == n - 1));
      chk($sformatf("%s.ready%0d", tag, i), 32'(rv[u]), 32'(i == n - 1));
    end
  endtask
  initial begin
    rst = 1'b1;
    lv = '0;
    d0 = '0;
    d1 = '0;
    d8 = '0;
    #2 rst = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) idle(u, "rst");
    for (int i = 0; i < 3; i++) begin
      lv[0] = 1'($urandom);
      d0 = 4'($urandom);
      step();
      idle(0, "rst_held");
    end
    rst = 1'b1;
    lv[0] = 1'b1;
    d0 = 4'b1011;
    word(0, "lsb", 8'b1011, 4, 0);
    step();
    idle(0, "lsb_end");
    chk("sipo_q", 32'(rq), 32'hB);
    lv[1] = 1'b1;
    d1 = 4'b1000;
    word(1, "msb", 8'b0001, 4, 0);
    step();
    idle(1, "msb_end");
    lv[0] = 1'b1;
    d0 = 4'hA;
    word(0, "b2b_a", 8'h0A, 4, 1);
    d0 = 4'h5;
    word(0, "b2b_5", 8'h05, 4, 1);
    lv[0] = 1'b0;
    step();
    idle(0, "b2b_end");
    lv[0] = 1'b1;
    d0 = 4'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      lv[0] = i == 1;
      if (i == 1) d0 = 4'hF;
      chk($sformatf("busy.b%0d", i), 32'(bv[0]), 0);
      chk($sformatf("busy.frame%0d", i), 32'(fv[0]), 1);
    end
    lv[0] = 1'b0;
    step();
    idle(0, "busy_end");
    lv[2] = 1'b1;
    d8 = 8'hC3;
    word(2, "w8", 8'hC3, 8, 0);
    step();
    idle(2, "w8_end");
    lv[0] = 1'b1;
    d0 = 4'b1011;
    step();
    lv[0] = 1'b0;
    step();
    chk("mid.b1", 32'(bv[0]), 1);
    chk("mid.frame1", 32'(fv[0]), 1);
    #2 rst = 1'b0;
    #1;
    idle(0, "mid_rst");
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      idle(0, $sformatf("mid_after%0d", i));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
